// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU sequencer and the instruction decoder.
// Phase codes are fixed because the decoder consumes them directly.
package cpu_pkg;
  localparam int STATE_W = 2;
  localparam int CNT_W   = 16;

  localparam logic [STATE_W-1:0] ST_FETCH = 2'b00;
  localparam logic [STATE_W-1:0] ST_EXEC1 = 2'b10;
  localparam logic [STATE_W-1:0] ST_EXEC2 = 2'b01;
  localparam logic [STATE_W-1:0] ST_HALT  = 2'b11;

  function automatic logic is_active(input logic [STATE_W-1:0] s);
    return s != ST_HALT;
  endfunction
endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and the rest of the CPU.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic               run;
  logic               step;
  logic               mem_ready;
  logic               sm_extra;
  logic               halt_req;
  logic               stop;
  logic               irq;
  logic [STATE_W-1:0] state;
  logic               irq_ack;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output run, step, mem_ready, sm_extra, halt_req, stop, irq,
    input  state, irq_ack, halted, fault, cycle_count, instr_count
  );

  modport slave (
    input  run, step, mem_ready, sm_extra, halt_req, stop, irq,
    output state, irq_ack, halted, fault, cycle_count, instr_count
  );
endinterface

// File: rtl/wrap_counter.sv
// Free-running wrap-around counter with synchronous clear (clear beats enable).
module wrap_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-phase sequencer: FETCH/EXEC1/EXEC2/HALT Moore FSM with
// single-step, halt request, interrupt acknowledge, fatal stop and counters.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  cpu_sequencer_if.slave bus
);
  logic [STATE_W-1:0] state_d, state_q;
  logic               sstep_d, sstep_q;
  logic               hreq_d, hreq_q;
  logic               fault_d, fault_q;
  logic               irq_ack_d, irq_ack_q;
  logic               complete;
  logic               halt_now;
  logic               cyc_en;
  logic               instr_en;

  always_comb begin
    state_d   = state_q;
    sstep_d   = sstep_q;
    hreq_d    = hreq_q;
    fault_d   = fault_q;
    irq_ack_d = 1'b0;
    complete  = 1'b0;
    halt_now  = hreq_q;

    case (state_q)
      ST_HALT: begin
        if (bus.run && !fault_q) begin
          state_d = ST_FETCH;
          sstep_d = 1'b0;
        end else if (bus.step && !fault_q) begin
          state_d = ST_FETCH;
          sstep_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ready) state_d = ST_EXEC1;
      end
      ST_EXEC1: begin
        // A halt request decoded here must survive into EXEC2 if the instruction needs it.
        halt_now = bus.halt_req;
        if (bus.sm_extra) begin
          state_d = ST_EXEC2;
          hreq_d  = bus.halt_req;
        end else begin
          complete = 1'b1;
        end
      end
      default: complete = 1'b1;
    endcase

    if (complete) begin
      hreq_d  = 1'b0;
      sstep_d = 1'b0;
      if (halt_now || sstep_q || !bus.run) begin
        state_d = ST_HALT;
      end else begin
        state_d   = ST_FETCH;
        irq_ack_d = bus.irq;
      end
    end

    // Fatal stop overrides everything, including a completion happening this cycle.
    if (bus.stop) begin
      state_d   = ST_HALT;
      fault_d   = 1'b1;
      irq_ack_d = 1'b0;
      hreq_d    = 1'b0;
      sstep_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_HALT;
      sstep_q   <= 1'b0;
      hreq_q    <= 1'b0;
      fault_q   <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sstep_q   <= sstep_d;
      hreq_q    <= hreq_d;
      fault_q   <= fault_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign cyc_en   = is_active(state_q);
  assign instr_en = complete && !bus.stop;

  wrap_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clock),
    .clr   (!reset_n),
    .en    (cyc_en),
    .count (bus.cycle_count)
  );

  wrap_counter #(.WIDTH(CNT_W)) u_instr_cnt (
    .clk   (clock),
    .clr   (!reset_n),
    .en    (instr_en),
    .count (bus.instr_count)
  );

  assign bus.state   = state_q;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.fault   = fault_q;
  assign bus.irq_ack = irq_ack_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer plus a narrow wrap_counter instance for wrap-around.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       w_clr;
  logic       w_en;
  logic [3:0] w_count;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  cpu_sequencer_if bus();

  cpu_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  wrap_counter #(.WIDTH(4)) u_wrap (
    .clk   (clock),
    .clr   (w_clr),
    .en    (w_en),
    .count (w_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.mem_ready = 1'b0;
    bus.sm_extra  = 1'b0;
    bus.halt_req  = 1'b0;
    bus.stop      = 1'b0;
    bus.irq       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.irq = 1'b1;
    repeat (4) tick();
    total_cnt++;
    if (bus.instr_count !== 16'd1) $display("FAIL rst_pre_instr: got %0d expected 1", bus.instr_count);
    else pass_cnt++;
    // Reset lands on an EXEC1 that would otherwise complete and ack irq
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.run = 1'b0; bus.irq = 1'b0;
    total_cnt++;
    if (bus.state !== ST_HALT) $display("FAIL rst_state: got %b expected %b", bus.state, ST_HALT);
    else pass_cnt++;
    total_cnt++;
    if (bus.halted !== 1'b1 || bus.fault !== 1'b0 || bus.irq_ack !== 1'b0)
      $display("FAIL rst_flags: got halted=%b fault=%b ack=%b expected 1 0 0", bus.halted, bus.fault, bus.irq_ack);
    else pass_cnt++;
    total_cnt++;
    if (bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0)
      $display("FAIL rst_counts: got cyc=%0d ins=%0d expected 0 0", bus.cycle_count, bus.instr_count);
    else pass_cnt++;
  endtask

  task automatic test_run3();
    logic [1:0] exp_s [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    do_reset();
    total_cnt++;
    if (bus.state !== 2'b11) $display("FAIL run3_init: got %b expected 11", bus.state);
    else pass_cnt++;
    bus.run = 1'b1; bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus.step = 1'b1;
      total_cnt++;
      if (bus.state !== exp_s[i]) $display("FAIL run3_state%0d: got %b expected %b", i, bus.state, exp_s[i]);
      else pass_cnt++;
    end
    bus.run = 1'b0;
    tick();
    bus.step = 1'b0;
    total_cnt++;
    if (bus.state !== 2'b11) $display("FAIL run3_final: got %b expected 11", bus.state);
    else pass_cnt++;
    total_cnt++;
    if (bus.instr_count !== 16'd3 || bus.cycle_count !== 16'd6)
      $display("FAIL run3_counts: got ins=%0d cyc=%0d expected 3 6", bus.instr_count, bus.cycle_count);
    else pass_cnt++;
  endtask

  task automatic test_step_wait();
    logic [1:0] exp_s [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};
    do_reset();
    bus.step = 1'b1; bus.sm_extra = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.step = 1'b0;
      if (i == 2) bus.mem_ready = 1'b1;
      total_cnt++;
      if (bus.state !== exp_s[i]) $display("FAIL step_state%0d: got %b expected %b", i, bus.state, exp_s[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.instr_count !== 16'd1 || bus.cycle_count !== 16'd5)
      $display("FAIL step_counts: got ins=%0d cyc=%0d expected 1 5", bus.instr_count, bus.cycle_count);
    else pass_cnt++;
  endtask

  task automatic test_halt_req();
    do_reset();
    bus.run = 1'b1; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.halt_req = 1'b1; bus.sm_extra = 1'b1;
    tick();
    bus.halt_req = 1'b0; bus.sm_extra = 1'b0;
    total_cnt++;
    if (bus.state !== ST_EXEC2 || bus.instr_count !== 16'd0)
      $display("FAIL hreq_exec2: got st=%b ins=%0d expected 01 0", bus.state, bus.instr_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.state !== ST_HALT || bus.halted !== 1'b1)
      $display("FAIL hreq_halt: got st=%b halted=%b expected 11 1", bus.state, bus.halted);
    else pass_cnt++;
    total_cnt++;
    if (bus.instr_count !== 16'd1) $display("FAIL hreq_instr: got %0d expected 1", bus.instr_count);
    else pass_cnt++;
    bus.run = 1'b0;
  endtask

  task automatic test_irq();
    do_reset();
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.irq = 1'b1;
    tick();
    total_cnt++;
    if (bus.irq_ack !== 1'b0) $display("FAIL irq_from_halt: got %b expected 0", bus.irq_ack);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (bus.irq_ack !== 1'b1 || bus.state !== ST_FETCH)
      $display("FAIL irq_ack: got ack=%b st=%b expected 1 00", bus.irq_ack, bus.state);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.irq_ack !== 1'b0 || bus.state !== ST_EXEC1)
      $display("FAIL irq_one_cycle: got ack=%b st=%b expected 0 10", bus.irq_ack, bus.state);
    else pass_cnt++;
    bus.run = 1'b0;
    tick();
    total_cnt++;
    if (bus.irq_ack !== 1'b0 || bus.state !== ST_HALT)
      $display("FAIL irq_to_halt: got ack=%b st=%b expected 0 11", bus.irq_ack, bus.state);
    else pass_cnt++;
    bus.irq = 1'b0;
  endtask

  task automatic test_stop();
    do_reset();
    bus.run = 1'b1; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.stop = 1'b1; bus.irq = 1'b1;
    tick();
    bus.stop = 1'b0; bus.irq = 1'b0;
    total_cnt++;
    if (bus.state !== ST_HALT || bus.fault !== 1'b1 || bus.irq_ack !== 1'b0)
      $display("FAIL stop_halt: got st=%b fault=%b ack=%b expected 11 1 0", bus.state, bus.fault, bus.irq_ack);
    else pass_cnt++;
    total_cnt++;
    if (bus.instr_count !== 16'd0 || bus.cycle_count !== 16'd2)
      $display("FAIL stop_counts: got ins=%0d cyc=%0d expected 0 2", bus.instr_count, bus.cycle_count);
    else pass_cnt++;
    tick();
    bus.run = 1'b0; bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    total_cnt++;
    if (bus.state !== ST_HALT || bus.fault !== 1'b1 || bus.cycle_count !== 16'd2)
      $display("FAIL stop_sticky: got st=%b fault=%b cyc=%0d expected 11 1 2", bus.state, bus.fault, bus.cycle_count);
    else pass_cnt++;
    bus.stop = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; bus.stop = 1'b0;
    total_cnt++;
    if (bus.fault !== 1'b0 || bus.state !== ST_HALT)
      $display("FAIL stop_reset: got fault=%b st=%b expected 0 11", bus.fault, bus.state);
    else pass_cnt++;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    total_cnt++;
    if (bus.state !== ST_FETCH) $display("FAIL stop_rerun: got %b expected 00", bus.state);
    else pass_cnt++;
  endtask

  task automatic test_run_step();
    logic [1:0] exp_s [4] = '{2'b00, 2'b10, 2'b00, 2'b10};
    do_reset();
    bus.run = 1'b1; bus.step = 1'b1; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.step = 1'b0;
      total_cnt++;
      if (bus.state !== exp_s[i]) $display("FAIL runstep_state%0d: got %b expected %b", i, bus.state, exp_s[i]);
      else pass_cnt++;
    end
    bus.run = 1'b0;
    tick();
    total_cnt++;
    if (bus.state !== ST_HALT || bus.instr_count !== 16'd2)
      $display("FAIL runstep_end: got st=%b ins=%0d expected 11 2", bus.state, bus.instr_count);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    w_clr = 1'b1; w_en = 1'b0;
    tick();
    w_clr = 1'b0; w_en = 1'b1;
    repeat (15) tick();
    total_cnt++;
    if (w_count !== 4'hF) $display("FAIL wrap_max: got %h expected f", w_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (w_count !== 4'h0) $display("FAIL wrap_zero: got %h expected 0", w_count);
    else pass_cnt++;
    tick();
    w_en = 1'b0;
    tick();
    total_cnt++;
    if (w_count !== 4'h1) $display("FAIL wrap_hold: got %h expected 1", w_count);
    else pass_cnt++;
    w_clr = 1'b1; w_en = 1'b1;
    tick();
    w_clr = 1'b0; w_en = 1'b0;
    total_cnt++;
    if (w_count !== 4'h0) $display("FAIL wrap_clr: got %h expected 0", w_count);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    w_clr = 1'b1;
    w_en  = 1'b0;
    reset_n = 1'b0;
    tick();
    test_reset();
    test_run3();
    test_step_wait();
    test_halt_req();
    test_irq();
    test_stop();
    test_run_step();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
